// File: rtl/battle_round_ctrl.sv
// Combat round sequencer: handshakes with the damage summer, applies damage to
// both bases with floor at zero, and tracks the game result and sticky error flags.
module battle_round_ctrl #(
  parameter logic [11:0] BASE_HP      = 12'd1000,
  parameter int          CALC_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        roundTick,
  input  logic        newGame,
  input  logic        calcDone,
  input  logic [11:0] totalUnitDamage,
  input  logic [11:0] totalEnemyDamage,
  output logic        calcStart,
  output logic        calcAck,
  output logic [11:0] playerHp,
  output logic [11:0] enemyHp,
  output logic [7:0]  roundCount,
  output logic        busy,
  output logic        gameOver,
  output logic        playerWon,
  output logic        draw,
  output logic        missedTick,
  output logic        timeoutErr
);

  // state | meaning
  // IDLE  | waiting for roundTick or newGame
  // START | calcStart pulse, timeout counter cleared
  // WAIT  | waiting for calcDone, timeout counter running
  // APPLY | subtract latched damage from both bases
  // ACK   | calcAck pulse, decide game over
  // OVER  | game finished, only newGame leaves
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] WAIT  = 3'd2;
  localparam logic [2:0] APPLY = 3'd3;
  localparam logic [2:0] ACK   = 3'd4;
  localparam logic [2:0] OVER  = 3'd5;

  localparam int CW = (CALC_TIMEOUT > 1) ? $clog2(CALC_TIMEOUT) : 1;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(CALC_TIMEOUT - 1);

  logic [2:0]    state, state_next;
  logic [CW-1:0] wait_cnt;
  logic [11:0]   unit_dmg, enemy_dmg;
  logic [12:0]   enemy_diff, player_diff;
  logic          any_dead;

  always_comb begin
    enemy_diff  = {1'b0, enemyHp} - {1'b0, unit_dmg};
    player_diff = {1'b0, playerHp} - {1'b0, enemy_dmg};
    any_dead    = (enemyHp == 12'd0) || (playerHp == 12'd0);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (newGame)        state_next = IDLE;
        else if (roundTick) state_next = START;
      end
      START: state_next = WAIT;
      WAIT: begin
        if (calcDone)                       state_next = APPLY;
        else if (wait_cnt == TIMEOUT_LAST)  state_next = IDLE;
      end
      APPLY: state_next = ACK;
      ACK:   state_next = any_dead ? OVER : IDLE;
      OVER:  state_next = newGame ? IDLE : OVER;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      unit_dmg   <= '0;
      enemy_dmg  <= '0;
      playerHp   <= BASE_HP;
      enemyHp    <= BASE_HP;
      roundCount <= '0;
      calcStart  <= 1'b0;
      calcAck    <= 1'b0;
      busy       <= 1'b0;
      gameOver   <= 1'b0;
      playerWon  <= 1'b0;
      draw       <= 1'b0;
      missedTick <= 1'b0;
      timeoutErr <= 1'b0;
    end else begin
      state     <= state_next;
      calcStart <= (state_next == START);
      calcAck   <= (state_next == ACK);
      busy      <= (state_next != IDLE) && (state_next != OVER);

      // busy mirrors START..ACK, so OVER drops ticks without flagging them
      if (roundTick && busy)
        missedTick <= 1'b1;

      case (state)
        IDLE, OVER: begin
          if (newGame) begin
            playerHp   <= BASE_HP;
            enemyHp    <= BASE_HP;
            roundCount <= '0;
            gameOver   <= 1'b0;
            playerWon  <= 1'b0;
            draw       <= 1'b0;
            missedTick <= 1'b0;
            timeoutErr <= 1'b0;
          end
        end
        START: wait_cnt <= '0;
        WAIT: begin
          if (calcDone) begin
            unit_dmg  <= totalUnitDamage;
            enemy_dmg <= totalEnemyDamage;
          end else if (wait_cnt == TIMEOUT_LAST) begin
            timeoutErr <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        APPLY: begin
          enemyHp  <= enemy_diff[12]  ? 12'd0 : enemy_diff[11:0];
          playerHp <= player_diff[12] ? 12'd0 : player_diff[11:0];
          if (roundCount != 8'hFF)
            roundCount <= roundCount + 8'd1;
        end
        ACK: begin
          if (any_dead) begin
            gameOver  <= 1'b1;
            playerWon <= (enemyHp == 12'd0) && (playerHp != 12'd0);
            draw      <= (enemyHp == 12'd0) && (playerHp == 12'd0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/battle_round_ctrl.md
BATTLE_ROUND_CTRL -- requirements
Module: battle_round_ctrl

Interface
REQ-001 The module SHALL have parameter BASE_HP, default 12'd1000, the starting hit points of each base.
REQ-002 The module SHALL have parameter CALC_TIMEOUT, default 64, the maximum number of WAIT cycles before the round is abandoned.
REQ-003 The module SHALL have port clk, input, 1 bit: system clock, all logic on posedge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The module SHALL have port roundTick, input, 1 bit: single-cycle pulse requesting one combat round.
REQ-006 The module SHALL have port newGame, input, 1 bit: single-cycle pulse that reloads both bases and clears round state.
REQ-007 The module SHALL have port calcDone, input, 1 bit: the damage summer's done level, held until acknowledged.
REQ-008 The module SHALL have port totalUnitDamage, input, 12 bits: summed player-unit damage, valid while calcDone=1.
REQ-009 The module SHALL have port totalEnemyDamage, input, 12 bits: summed enemy damage, valid while calcDone=1.
REQ-010 The module SHALL have port calcStart, output, 1 bit: single-cycle start pulse to the damage summer.
REQ-011 The module SHALL have port calcAck, output, 1 bit: single-cycle acknowledge to the damage summer.
REQ-012 The module SHALL have port playerHp, output, 12 bits: player base hit points.
REQ-013 The module SHALL have port enemyHp, output, 12 bits: enemy base hit points.
REQ-014 The module SHALL have port roundCount, output, 8 bits: completed rounds.
REQ-015 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE or OVER.
REQ-016 The module SHALL have ports gameOver, playerWon and draw, outputs, 1 bit each: game result flags.
REQ-017 The module SHALL have ports missedTick and timeoutErr, outputs, 1 bit each: sticky error flags.

Function
REQ-018 The state machine SHALL have the states IDLE, START, WAIT, APPLY, ACK and OVER, and all outputs SHALL be registered.
REQ-019 In IDLE, when roundTick=1, the machine SHALL go to START on the next cycle.
REQ-020 In START, calcStart SHALL be 1 for exactly that one cycle, the timeout counter SHALL clear to 0, and the machine SHALL go to WAIT.
REQ-021 In WAIT with calcDone=1, both damage inputs SHALL be latched and the machine SHALL go to APPLY.
REQ-022 In WAIT with calcDone=0, the timeout counter SHALL increment, and when it reaches CALC_TIMEOUT-1 the machine SHALL set timeoutErr, go to IDLE, and apply no damage.
REQ-023 In APPLY, enemyHp SHALL become max(enemyHp - latched unit damage, 0) and playerHp SHALL become max(playerHp - latched enemy damage, 0), using 13-bit subtraction with borrow detection.
REQ-024 In APPLY, roundCount SHALL increment and saturate at 255, and the machine SHALL go to ACK.
REQ-025 In ACK, calcAck SHALL be 1 for exactly one cycle, after which the machine SHALL go to OVER if either HP is 0, else to IDLE.
REQ-026 In OVER, gameOver SHALL be 1.
REQ-027 In OVER, playerWon SHALL be 1 when enemyHp=0 and playerHp≠0.
REQ-028 In OVER, draw SHALL be 1 when both HP are 0.
REQ-029 In OVER, roundTick SHALL be ignored.
REQ-030 newGame SHALL be honoured only in IDLE or OVER, and the next cycle SHALL load both HP with BASE_HP, clear roundCount, gameOver, playerWon, draw, missedTick and timeoutErr, and enter IDLE.
REQ-031 newGame SHALL be ignored in START, WAIT, APPLY and ACK.
REQ-032 When roundTick=1 while busy=1, missedTick SHALL be set (sticky) and the tick dropped, with no queueing.
REQ-033 When roundTick=1 and newGame=1 arrive in the same IDLE cycle, newGame SHALL win and the tick SHALL be dropped without setting missedTick.
REQ-034 Damage of 0 SHALL leave HP unchanged, and damage ≥ HP SHALL set HP to exactly 0.
REQ-035 The latency from roundTick to calcStart SHALL be 1 cycle.
REQ-036 The latency from calcDone sampled in WAIT to updated HP SHALL be 2 cycles.
REQ-037 The latency from calcDone sampled in WAIT to calcAck high SHALL be 2 cycles.

Reset
REQ-038 When rst=1, the state SHALL become IDLE, with priority over all other inputs.
REQ-039 When rst=1, playerHp and enemyHp SHALL load BASE_HP.
REQ-040 When rst=1, roundCount and the timeout counter SHALL load 0.
REQ-041 When rst=1, calcStart, calcAck, busy, gameOver, playerWon, draw, missedTick and timeoutErr SHALL load 0.
REQ-042 rst asserted mid-round SHALL abort the round without applying damage and without issuing calcAck.

Verification
REQ-043 The bench SHALL cover: reset, roundTick, calcDone after 16 cycles with unit=100 and enemy=40 -> enemyHp=900, playerHp=960, roundCount=1, one calcStart pulse and one calcAck pulse.
REQ-044 The bench SHALL cover: enemyHp=50 with unit damage 300 -> enemyHp=0, OVER, gameOver=1, playerWon=1.
REQ-045 The bench SHALL cover: both HP=10 with both damages 10 -> both HP=0, draw=1, playerWon=0.
REQ-046 The bench SHALL cover: calcDone never asserted -> timeoutErr=1 after 64 WAIT cycles, back to IDLE, HP unchanged.
REQ-047 The bench SHALL cover: roundTick during WAIT -> missedTick=1, exactly one round completed; then newGame in IDLE -> flags clear, HP=1000.
REQ-048 The bench SHALL cover: rst during WAIT -> IDLE next cycle, HP=1000, calcAck never pulsed.
